// File: rtl/pow_5_result_history.sv
// pow_5_result_history: keeps the newest DEPTH fifth-power results for a hex
// display, along with per-digit enables, a saturating result count and a
// "new result" LED that stays lit for a while after each capture.
// Optional macro POW_5_RESULT_HISTORY_FREEZE_EN adds a freeze input. While
// freeze is high the display holds still, but arrivals are still counted and
// still light the LED.

// One history slot: cleared, loaded from its neighbour on a shift, or held.
module pow_5_result_history_entry #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_d, q_q;

    // Next slot value. Clear wins over shift.
    always_comb begin
        q_d = q_q;
        if (clear)      q_d = '0;
        else if (shift) q_d = d;
    end

    // Slot register.
    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;
endmodule

module pow_5_result_history #(
    parameter int W       = 8,
    parameter int DEPTH   = 4,
    parameter int STRETCH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic                   clr,
`ifdef POW_5_RESULT_HISTORY_FREEZE_EN
    input  logic                   freeze,
`endif
    input  logic                   res_vld,
    input  logic [W-1:0]           res,
    output logic [DEPTH*W-1:0]     hist,
    output logic [DEPTH*W/4-1:0]   hist_en,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic [7:0]             cnt,
    output logic                   vld_led
);
    localparam int DIGS = W / 4;
    localparam int FW   = $clog2(DEPTH + 1);
    localparam int SW   = $clog2(STRETCH + 1);

    logic                   clear, accept, hold, shift;
    logic [DEPTH-1:0][W-1:0] hist_q;
    logic [FW-1:0]          fill_d, fill_q;
    logic [7:0]             cnt_d, cnt_q;
    logic [SW-1:0]          stretch_d, stretch_q;
    logic                   vld_led_d, vld_led_q;

    assign clear  = clk_en & clr;
    assign accept = clk_en & res_vld & ~clr;
`ifdef POW_5_RESULT_HISTORY_FREEZE_EN
    assign hold   = freeze;
`else
    assign hold   = 1'b0;
`endif
    // Frozen accepts still count and still light the LED. They just don't move the display.
    assign shift  = accept & ~hold;

    // Shift chain. Entry 0 takes the new result, and entry k takes entry k-1.
    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        if (k == 0) begin : g_head
            pow_5_result_history_entry #(.W(W)) u_entry (
                .clk(clk), .rst(rst), .clear(clear), .shift(shift),
                .d(res), .q(hist_q[k])
            );
        end else begin : g_tail
            pow_5_result_history_entry #(.W(W)) u_entry (
                .clk(clk), .rst(rst), .clear(clear), .shift(shift),
                .d(hist_q[k-1]), .q(hist_q[k])
            );
        end
        // All digits of an entry turn on together once that entry is filled.
        assign hist_en[k*DIGS +: DIGS] = {DIGS{fill_q > FW'(k)}};
    end

    // Next fill, count, stretch and LED state.
    always_comb begin
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        stretch_d = stretch_q;
        if (clear) begin
            fill_d    = '0;
            cnt_d     = '0;
            stretch_d = '0;
        end else if (accept) begin
            if (shift && fill_q != FW'(DEPTH)) fill_d = fill_q + FW'(1);
            if (cnt_q != 8'hFF)                cnt_d  = cnt_q + 8'd1;
            stretch_d = SW'(STRETCH);
        end else if (clk_en && stretch_q != '0) begin
            stretch_d = stretch_q - SW'(1);
        end
        vld_led_d = (stretch_d != '0);
    end

    // Registered state. Reset is not gated by clk_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q    <= '0;
            cnt_q     <= '0;
            stretch_q <= '0;
            vld_led_q <= 1'b0;
        end else begin
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            stretch_q <= stretch_d;
            vld_led_q <= vld_led_d;
        end
    end

    assign hist    = hist_q;
    assign fill    = fill_q;
    assign cnt     = cnt_q;
    assign vld_led = vld_led_q;
endmodule
